// File: rtl/alu_result_stage.sv
// alu_result_stage: opcode-driven result select with NZCV flags behind a two-entry skid buffer
package alu_ops;
    localparam logic [3:0] OP_LL  = 4'd0;
    localparam logic [3:0] OP_LR  = 4'd1;
    localparam logic [3:0] OP_AL  = 4'd2;
    localparam logic [3:0] OP_AR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_ADD = 4'd8;
    localparam logic [3:0] OP_SUB = 4'd9;
endpackage

module alu_result_stage
    import alu_ops::*;
#(
    parameter int W         = 4,
    parameter int OP_W      = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      opcode,
    input  logic [W-1:0]         operand_a,
    input  logic [W-1:0]         operand_b,
    input  logic                 arith_carry,
    input  logic [W-1:0]         ll_res,
    input  logic [W-1:0]         lr_res,
    input  logic [W-1:0]         al_res,
    input  logic [W-1:0]         ar_res,
    input  logic [W-1:0]         not_res,
    input  logic [W-1:0]         and_res,
    input  logic [W-1:0]         or_res,
    input  logic [W-1:0]         xor_res,
    input  logic [W-1:0]         add_res,
    input  logic [W-1:0]         sub_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_result,
    output logic [3:0]           out_flags,
    output logic [OP_W-1:0]      out_opcode,
    output logic                 out_illegal,
    output logic [ERR_CNT_W-1:0] illegal_count
);
    logic            acc, pop, ill, c, v;
    logic [W-1:0]    sel;
    logic [3:0]      flags;
    logic            skid_valid, skid_illegal;
    logic [W-1:0]    skid_result;
    logic [3:0]      skid_flags;
    logic [OP_W-1:0] skid_opcode;

    assign in_ready = !skid_valid;
    assign acc      = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;

    // pick the functional-unit result named by the opcode; unknown codes fall back to ll_res
    always_comb begin
        sel = ll_res;
        ill = 1'b0;
        case (opcode)
            OP_LL:   sel = ll_res;
            OP_LR:   sel = lr_res;
            OP_AL:   sel = al_res;
            OP_AR:   sel = ar_res;
            OP_NOT:  sel = not_res;
            OP_AND:  sel = and_res;
            OP_OR:   sel = or_res;
            OP_XOR:  sel = xor_res;
            OP_ADD:  sel = add_res;
            OP_SUB:  sel = sub_res;
            default: ill = 1'b1;
        endcase
    end

    // carry and signed overflow only mean something for the adder opcodes
    always_comb begin
        c = (opcode == OP_ADD || opcode == OP_SUB) && arith_carry;
        v = opcode == OP_ADD ? (operand_a[W-1] == operand_b[W-1]) && (sel[W-1] != operand_a[W-1]) :
            opcode == OP_SUB ? (operand_a[W-1] != operand_b[W-1]) && (sel[W-1] != operand_a[W-1]) :
            1'b0;
        flags = {sel[W-1], sel == '0, c, v};
    end

    // OUT/SKID pair: SKID only fills when OUT is stalled, and drains into OUT on the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_flags    <= '0;
            out_opcode   <= '0;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_result  <= '0;
            skid_flags   <= '0;
            skid_opcode  <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (pop) begin
                out_result  <= skid_result;
                out_flags   <= skid_flags;
                out_opcode  <= skid_opcode;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
            end
        end else if (acc) begin
            if (!out_valid || pop) begin
                out_valid   <= 1'b1;
                out_result  <= sel;
                out_flags   <= flags;
                out_opcode  <= opcode;
                out_illegal <= ill;
            end else begin
                skid_valid   <= 1'b1;
                skid_result  <= sel;
                skid_flags   <= flags;
                skid_opcode  <= opcode;
                skid_illegal <= ill;
            end
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    // saturating tally of illegal beats actually taken in; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst)
            illegal_count <= '0;
        else if (acc && ill && ~&illegal_count)
            illegal_count <= illegal_count + ERR_CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized and directed checks of alu_result_stage against a queue model
module tb_alu_result_stage;
    import alu_ops::*;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready, arith_carry;
    logic [3:0] opcode, operand_a, operand_b;
    logic [3:0] fu [10];
    logic       in_ready, out_valid, out_illegal;
    logic [3:0] out_result, out_flags, out_opcode;
    logic [7:0] illegal_count;
    logic       s_in_ready, s_out_valid, s_out_illegal;
    logic [3:0] s_out_result, s_out_flags, s_out_opcode;
    logic [1:0] s_count;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic [3:0] op;
        logic       ill;
    } beat_t;

    beat_t q[$];
    int    cnt = 0, cnt2 = 0;
    int    passed = 0, failed = 0, total = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.W(4), .OP_W(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b), .arith_carry(arith_carry),
        .ll_res(fu[0]), .lr_res(fu[1]), .al_res(fu[2]), .ar_res(fu[3]), .not_res(fu[4]),
        .and_res(fu[5]), .or_res(fu[6]), .xor_res(fu[7]), .add_res(fu[8]), .sub_res(fu[9]),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_opcode(out_opcode), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    alu_result_stage #(.W(4), .OP_W(4), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b), .arith_carry(arith_carry),
        .ll_res(fu[0]), .lr_res(fu[1]), .al_res(fu[2]), .ar_res(fu[3]), .not_res(fu[4]),
        .and_res(fu[5]), .or_res(fu[6]), .xor_res(fu[7]), .add_res(fu[8]), .sub_res(fu[9]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_flags(s_out_flags), .out_opcode(s_out_opcode), .out_illegal(s_out_illegal),
        .illegal_count(s_count)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t ref_beat();
        beat_t b;
        logic  arith;
        b.ill = opcode > 4'd9;
        b.res = b.ill ? fu[0] : fu[opcode];
        b.op  = opcode;
        arith = (opcode == OP_ADD) || (opcode == OP_SUB);
        b.flags[3] = b.res[3];
        b.flags[2] = (b.res == 4'd0);
        b.flags[1] = arith ? arith_carry : 1'b0;
        if (opcode == OP_ADD)
            b.flags[0] = (operand_a[3] == operand_b[3]) && (b.res[3] != operand_a[3]);
        else if (opcode == OP_SUB)
            b.flags[0] = (operand_a[3] != operand_b[3]) && (b.res[3] != operand_a[3]);
        else
            b.flags[0] = 1'b0;
        return b;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op);
        in_valid    = v;
        opcode      = op;
        operand_a   = 4'($urandom);
        operand_b   = 4'($urandom);
        arith_carry = 1'($urandom);
        for (int i = 0; i < 10; i++) fu[i] = 4'($urandom);
    endtask

    task automatic tick();
        beat_t b;
        bit    acc, pop;
        if (rst) begin
            q.delete();
            cnt  = 0;
            cnt2 = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
            b   = ref_beat();
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(b);
                if (b.ill) begin
                    cnt  = (cnt < 255) ? cnt + 1 : cnt;
                    cnt2 = (cnt2 < 3) ? cnt2 + 1 : cnt2;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 8'(out_valid), 8'(q.size() > 0));
        chk("in_ready", 8'(in_ready), 8'(q.size() < 2));
        chk("illegal_count", illegal_count, 8'(cnt));
        chk("sat_count", 8'(s_count), 8'(cnt2));
        if (q.size() > 0) begin
            chk("out_result", 8'(out_result), 8'(q[0].res));
            chk("out_flags", 8'(out_flags), 8'(q[0].flags));
            chk("out_opcode", 8'(out_opcode), 8'(q[0].op));
            chk("out_illegal", 8'(out_illegal), 8'(q[0].ill));
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_result", 8'(out_result), 8'd0);
        chk("rst_flags", 8'(out_flags), 8'd0);
        chk("rst_opcode", 8'(out_opcode), 8'd0);
        chk("rst_illegal", 8'(out_illegal), 8'd0);

        drive(1'b1, OP_ADD);
        operand_a = 4'd7; operand_b = 4'd1; fu[8] = 4'd8; arith_carry = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("add_result", 8'(out_result), 8'd8);
        chk("add_flags", 8'(out_flags), 8'b1001);

        drive(1'b1, OP_SUB);
        operand_a = 4'd3; operand_b = 4'd3; fu[9] = 4'd0; arith_carry = 1'b0;
        tick();
        chk("sub_zero_flags", 8'(out_flags), 8'b0100);
        drive(1'b1, OP_SUB);
        operand_a = 4'd8; operand_b = 4'd1; fu[9] = 4'd7; arith_carry = 1'b0;
        tick();
        chk("sub_ovf_result", 8'(out_result), 8'd7);
        chk("sub_ovf_flags", 8'(out_flags), 8'b0001);

        drive(1'b0, 4'd0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, OP_AND); tick();
        drive(1'b1, OP_OR);  tick();
        chk("stall_ready_low", 8'(in_ready), 8'd0);
        drive(1'b1, OP_XOR); tick(); tick();
        out_ready = 1'b1;
        tick();
        chk("release_ready_high", 8'(in_ready), 8'd1);
        tick();
        drive(1'b0, 4'd0);
        tick();
        tick();

        drive(1'b1, 4'hC);
        fu[0] = 4'd5;
        tick();
        chk("illegal_result", 8'(out_result), 8'd5);
        chk("illegal_flag", 8'(out_illegal), 8'd1);
        chk("illegal_count_1", illegal_count, 8'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(10 + $urandom_range(0, 5)));
            tick();
        end
        chk("sat_count_3", 8'(s_count), 8'd3);
        chk("illegal_count_6", illegal_count, 8'd6);

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'($urandom_range(0, 11)));
            tick();
        end

        out_ready = 1'b0;
        drive(1'b1, 4'($urandom_range(0, 15))); tick();
        drive(1'b1, 4'($urandom_range(0, 15))); tick();
        drive(1'b1, 4'($urandom_range(0, 15)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 8'(out_valid), 8'd0);
        chk("flush_count_kept", illegal_count, 8'(cnt));
        drive(1'b1, 4'hE); tick();
        drive(1'b1, 4'($urandom_range(0, 15))); tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_result", 8'(out_result), 8'd0);
        chk("rst2_flags", 8'(out_flags), 8'd0);
        chk("rst2_opcode", 8'(out_opcode), 8'd0);
        chk("rst2_illegal", 8'(out_illegal), 8'd0);
        chk("rst2_count", illegal_count, 8'd0);

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 4'($urandom));
            out_ready = 1'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 4'd0);
        out_ready = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
